// File: rtl/filter_sequencer_if.sv
// Signal bundle between the filter sequencer and its environment: sample
// memory read port, filter engine handshake, UART transmitter and run status.
// The sequencer takes the master view; memory/engine/UART take the slave view.
interface filter_sequencer_if;
   logic       buf_done;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] flt_in;
   logic       flt_in_valid;
   logic       flt_ready;
   logic [7:0] flt_out;
   logic       flt_out_valid;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       busy;
   logic       run_done;
   logic       err;

   modport master (
      input  buf_done,
      output rd_addr,
      input  rd_data,
      output flt_in,
      output flt_in_valid,
      input  flt_ready,
      input  flt_out,
      input  flt_out_valid,
      output tx_data,
      output tx_start,
      input  tx_busy,
      output busy,
      output run_done,
      output err
   );

   modport slave (
      output buf_done,
      input  rd_addr,
      output rd_data,
      input  flt_in,
      input  flt_in_valid,
      output flt_ready,
      output flt_out,
      output flt_out_valid,
      input  tx_data,
      input  tx_start,
      output tx_busy,
      input  busy,
      input  run_done,
      input  err
   );
endinterface

// File: rtl/filter_sequencer.sv
// Filter sequencer: walks the 256 samples of a loaded buffer, pushes each one
// through the filter engine and streams the result as three ASCII decimal
// digits plus a separator (',' between results, LF after the last) to a UART.
// A filter engine that stays silent for 255 cycles is reported through the
// sticky err flag and its result is sent as 000.
module filter_sequencer (
   input  logic               clk,
   input  logic               rst,
   filter_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT_RES,
      TX_CHAR,
      TX_WAIT,
      DONE
   } state_t;

   localparam logic [7:0] LAST_IDX     = 8'd255;
   localparam logic [7:0] TIMEOUT_LAST = 8'd254;
   localparam logic [7:0] ASCII_ZERO   = 8'h30;
   localparam logic [7:0] SEP_COMMA    = 8'h2C;
   localparam logic [7:0] SEP_LF       = 8'h0A;
   localparam logic [1:0] LAST_CHAR    = 2'd3;

   state_t     state;
   logic [7:0] idx;
   logic [7:0] result;
   logic [7:0] tmo_cnt;
   logic [1:0] char_cnt;
   logic       issue_loaded;
   logic       wait_first;

   logic [7:0] digit_hund;
   logic [7:0] digit_tens;
   logic [7:0] digit_ones;
   logic [7:0] char_sel;

   // Character selected by char_cnt: hundreds, tens, ones digit, then separator
   always_comb begin
      digit_hund = result / 8'd100;
      digit_tens = (result / 8'd10) % 8'd10;
      digit_ones = result % 8'd10;
      case (char_cnt)
         2'd0:    char_sel = ASCII_ZERO + digit_hund;
         2'd1:    char_sel = ASCII_ZERO + digit_tens;
         2'd2:    char_sel = ASCII_ZERO + digit_ones;
         default: char_sel = (idx == LAST_IDX) ? SEP_LF : SEP_COMMA;
      endcase
   end

   // Sequencer FSM; every output is a register updated here
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         idx              <= '0;
         result           <= '0;
         tmo_cnt          <= '0;
         char_cnt         <= '0;
         issue_loaded     <= 1'b0;
         wait_first       <= 1'b0;
         bus.rd_addr      <= '0;
         bus.flt_in       <= '0;
         bus.flt_in_valid <= 1'b0;
         bus.tx_data      <= '0;
         bus.tx_start     <= 1'b0;
         bus.busy         <= 1'b0;
         bus.run_done     <= 1'b0;
         bus.err          <= 1'b0;
      end else begin
         bus.tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.buf_done) begin
                  idx         <= '0;
                  bus.rd_addr <= '0;
                  bus.busy    <= 1'b1;
                  state       <= FETCH;
               end
            end

            FETCH: begin
               issue_loaded <= 1'b0;
               state        <= ISSUE;
            end

            ISSUE: begin
               if (!issue_loaded) begin
                  bus.flt_in       <= bus.rd_data;
                  bus.flt_in_valid <= 1'b1;
                  issue_loaded     <= 1'b1;
               end else if (bus.flt_ready) begin
                  bus.flt_in_valid <= 1'b0;
                  tmo_cnt          <= '0;
                  state            <= WAIT_RES;
               end
            end

            WAIT_RES: begin
               if (bus.flt_out_valid) begin
                  result   <= bus.flt_out;
                  char_cnt <= '0;
                  state    <= TX_CHAR;
               end else if (tmo_cnt == TIMEOUT_LAST) begin
                  bus.err  <= 1'b1;
                  result   <= '0;
                  char_cnt <= '0;
                  state    <= TX_CHAR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            TX_CHAR: begin
               if (!bus.tx_busy) begin
                  bus.tx_data  <= char_sel;
                  bus.tx_start <= 1'b1;
                  wait_first   <= 1'b1;
                  state        <= TX_WAIT;
               end
            end

            TX_WAIT: begin
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (!bus.tx_busy) begin
                  if (char_cnt != LAST_CHAR) begin
                     char_cnt <= char_cnt + 2'd1;
                     state    <= TX_CHAR;
                  end else if (idx == LAST_IDX) begin
                     bus.busy     <= 1'b0;
                     bus.run_done <= 1'b1;
                     state        <= DONE;
                  end else begin
                     idx         <= idx + 8'd1;
                     bus.rd_addr <= idx + 8'd1;
                     state       <= FETCH;
                  end
               end
            end

            DONE: begin
               state <= DONE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: sample memory, filter engine and UART models
// around the DUT, an expected character stream built from decimal formatting,
// and a single negedge process that drives the models and checks the DUT.
module tb_filter_sequencer;

   logic clk = 1'b0;
   logic rst;

   filter_sequencer_if bus ();

   filter_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];
   logic [7:0] exp_q [$];
   logic [7:0] rx [1024];
   int rx_count;
   int accepts;

   int tx_len;
   int tmo_idx;
   bit bp_en;
   bit stuck_en;
   bit stray_en;

   int stuck_starts;
   bit bp_done;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Expected stream: three zero-padded decimal digits and a separator per index
   task automatic build_expected();
      string s;
      logic [7:0] v;
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
         v = (i == tmo_idx) ? 8'd0 : mem[i];
         s = $sformatf("%03d", v);
         exp_q.push_back(s[0]);
         exp_q.push_back(s[1]);
         exp_q.push_back(s[2]);
         exp_q.push_back((i == 255) ? 8'h0A : 8'h2C);
      end
   endtask

   task automatic check_str(input string name, input int start, input string lit);
      for (int k = 0; k < lit.len(); k++)
         check_output($sformatf("%s[%0d]", name, k), rx[start + k], lit[k]);
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_rd_addr"}, bus.rd_addr, 0);
      check_output({tag, "_flt_in"}, bus.flt_in, 0);
      check_output({tag, "_flt_in_valid"}, bus.flt_in_valid, 0);
      check_output({tag, "_tx_data"}, bus.tx_data, 0);
      check_output({tag, "_tx_start"}, bus.tx_start, 0);
      check_output({tag, "_busy"}, bus.busy, 0);
      check_output({tag, "_run_done"}, bus.run_done, 0);
      check_output({tag, "_err"}, bus.err, 0);
   endtask

   task automatic apply_stimulus(input string tag);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero(tag);
      build_expected();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_output({tag, "_restart_busy"}, bus.busy, 1);
      check_output({tag, "_restart_rd_addr"}, bus.rd_addr, 0);
   endtask

   task automatic wait_done(input string name, input int bound);
      int n = 0;
      while (!bus.run_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      check_output(name, bus.run_done, 1);
   endtask

   // Environment models and the per-cycle compare process
   initial begin : env
      int busy_left;
      int stuck;
      bit tx_pend;
      int resp_cnt;
      logic [7:0] resp_val;
      int bp_left;
      bit accept;
      bit prev_valid;
      bit prev_accept;
      bit prev_start;
      logic [7:0] prev_flt_in;
      logic [7:0] last_tx;
      logic [7:0] rd_addr_q;
      logic [7:0] exp_c;
      bit tmo_armed;
      int tmo_cycles;

      busy_left = 0; stuck = 0; tx_pend = 0; resp_cnt = 0; resp_val = 0;
      bp_left = 0; prev_valid = 0; prev_accept = 0; prev_start = 0;
      prev_flt_in = 0; last_tx = 0; rd_addr_q = 0; tmo_armed = 0; tmo_cycles = 0;
      rx_count = 0; accepts = 0; stuck_starts = 0; bp_done = 0;
      bus.rd_data = 0; bus.flt_ready = 0; bus.flt_out = 8'h5A;
      bus.flt_out_valid = 0; bus.tx_busy = 0;

      forever begin
         @(negedge clk);
         if (rst) begin
            busy_left = 0; stuck = 0; tx_pend = 0; resp_cnt = 0; bp_left = 0;
            prev_valid = 0; prev_accept = 0; prev_start = 0; last_tx = 0;
            tmo_armed = 0; rx_count = 0; accepts = 0; stuck_starts = 0; bp_done = 0;
            bus.flt_ready = 0; bus.flt_out_valid = 0; bus.tx_busy = 0;
         end else begin
            if (bus.tx_start) begin
               check_output("tx_start_while_busy", bus.tx_busy, 0);
               check_output("tx_start_with_flt_valid", bus.flt_in_valid, 0);
               check_output("tx_start_consecutive", prev_start, 0);
               if (exp_q.size() == 0) begin
                  check_output("tx_extra_char", 1, 0);
               end else begin
                  exp_c = exp_q.pop_front();
                  check_output($sformatf("tx_char[%0d]", rx_count), bus.tx_data, exp_c);
               end
               if (rx_count < 1024) rx[rx_count] = bus.tx_data;
               rx_count++;
               if (stuck > 0) stuck_starts++;
               last_tx = bus.tx_data;
            end else begin
               check_output("tx_data_hold", bus.tx_data, last_tx);
            end

            if (prev_accept) begin
               check_output("flt_valid_drop", bus.flt_in_valid, 0);
            end else if (prev_valid) begin
               check_output("flt_valid_hold", bus.flt_in_valid, 1);
               check_output("flt_in_stable", bus.flt_in, prev_flt_in);
            end

            if (tmo_armed) begin
               if (bus.err) begin
                  check_output("err_latency", tmo_cycles, 255);
                  tmo_armed = 0;
               end else if (tmo_cycles > 400) begin
                  check_output("err_never_set", bus.err, 1);
                  tmo_armed = 0;
               end else begin
                  tmo_cycles++;
               end
            end

            bus.flt_out_valid = 0;
            bus.flt_out = 8'h5A;
            if (resp_cnt > 0) begin
               resp_cnt--;
               if (resp_cnt == 0) begin
                  bus.flt_out_valid = 1;
                  bus.flt_out = resp_val;
               end
            end

            if (busy_left > 0) busy_left--;
            if (stuck > 0) stuck--;
            if (tx_pend) begin
               busy_left = tx_len;
               tx_pend = 0;
               if (stray_en) begin
                  bus.flt_out_valid = 1;
                  bus.flt_out = 8'hEE;
               end
            end
            if (bus.tx_start) tx_pend = 1;

            if (bp_en && !bp_done && accepts == 5 && bus.flt_in_valid) begin
               bp_left = 5;
               bp_done = 1;
            end
            if (bp_left > 0) begin
               bus.flt_ready = 0;
               bp_left--;
            end else begin
               bus.flt_ready = 1;
            end
            accept = bus.flt_in_valid && bus.flt_ready;
            if (accept) begin
               if (accepts < 256)
                  check_output($sformatf("flt_in_sample[%0d]", accepts), bus.flt_in, mem[accepts]);
               else
                  check_output("flt_extra_accept", accepts, 255);
               if (accepts == tmo_idx) begin
                  tmo_armed = 1;
                  tmo_cycles = 0;
               end else begin
                  resp_cnt = 2;
                  resp_val = bus.flt_in;
               end
               if (stuck_en && accepts == 7) stuck = 50;
               accepts++;
            end
            bus.tx_busy = (busy_left > 0) || (stuck > 0);

            bus.rd_data = mem[rd_addr_q];
            rd_addr_q = bus.rd_addr;

            prev_valid = bus.flt_in_valid;
            prev_accept = accept;
            prev_flt_in = bus.flt_in;
            prev_start = bus.tx_start;
         end
      end
   end

   // Directed runs: ideal, faulted (timeout/backpressure/stuck UART/strays), mid-run reset
   initial begin : main
      int n;
      rst = 1'b1;
      bus.buf_done = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = i[7:0];
      tx_len = 10; tmo_idx = -1; bp_en = 0; stuck_en = 0; stray_en = 0;

      repeat (3) @(negedge clk);
      check_all_zero("por");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_output("idle_busy", bus.busy, 0);
      check_output("idle_no_tx", rx_count, 0);

      build_expected();
      bus.buf_done = 1'b1;
      wait_done("run1_done", 30000);
      check_output("run1_chars", rx_count, 1024);
      check_output("run1_left", exp_q.size(), 0);
      check_output("run1_accepts", accepts, 256);
      check_output("run1_busy", bus.busy, 0);
      check_output("run1_err", bus.err, 0);
      check_str("enc_000", 0, "000,");
      check_str("enc_009", 36, "009,");
      check_str("enc_010", 40, "010,");
      check_str("enc_099", 396, "099,");
      check_str("enc_100", 400, "100,");
      check_str("enc_255", 1020, "255\n");

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.buf_done = i[0];
      end
      check_output("done_no_tx", rx_count, 1024);
      check_output("done_sticky", bus.run_done, 1);
      check_output("done_busy", bus.busy, 0);

      bus.buf_done = 1'b1;
      tx_len = 4; tmo_idx = 3; bp_en = 1; stuck_en = 1; stray_en = 1;
      apply_stimulus("rst2");
      wait_done("run2_done", 30000);
      check_output("run2_chars", rx_count, 1024);
      check_output("run2_left", exp_q.size(), 0);
      check_output("run2_accepts", accepts, 256);
      check_output("run2_err", bus.err, 1);
      check_output("run2_busy", bus.busy, 0);
      check_output("run2_stuck_starts", stuck_starts, 0);
      check_str("tmo_000", 12, "000,");
      check_str("bp_005", 20, "005,");
      check_str("stuck_007", 28, "007,");

      tx_len = 4; tmo_idx = -1; bp_en = 0; stuck_en = 0; stray_en = 0;
      apply_stimulus("rst3");
      n = 0;
      while (rx_count < 402 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_output("run3_reach_idx100", rx_count >= 402, 1);
      apply_stimulus("rst_mid");
      wait_done("run3_done", 30000);
      check_output("run3_chars", rx_count, 1024);
      check_output("run3_left", exp_q.size(), 0);
      check_output("run3_accepts", accepts, 256);
      check_output("run3_err", bus.err, 0);
      check_str("run3_first", 0, "000,");
      check_str("run3_last", 1020, "255\n");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
